sim_frame_check: RTL

Byte-stream frame receiver and checker for the 2048-byte test frames driven on the 8-bit `s2p_dout_o` / `dout_start` bus. It sits at the consuming end of that bus, in loopback benches or on the far side of the link. For each frame it:
- parses the 22-byte header,
- classifies the frame kind,
- extracts the dangwei code,
- verifies the incrementing payload pattern,
- publishes per-frame status plus saturating good/bad frame counters.

---
 rtl/sim_frame_check.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/sim_frame_check.sv
// sim_frame_check: receives 2048-byte test frames, checks the header and the incrementing payload, and reports per-frame status and counts.
module sim_frame_check (
  input  logic        sys_clk_i,
  input  logic        rst_n_i,
  input  logic [7:0]  s2p_din_i,
  input  logic        din_valid_i,
  output logic        frame_done_o,
  output logic        frame_ok_o,
  output logic [1:0]  frame_kind_o,
  output logic [7:0]  dangwei_o,
  output logic        hdr_err_o,
  output logic        pld_err_o,
  output logic        len_err_o,
  output logic [10:0] err_idx_o,
  output logic [15:0] good_cnt_o,
  output logic [15:0] bad_cnt_o
);
  typedef enum logic [1:0] {IDLE, HDR, PLD, DONE} state_t;
  state_t      state_q, state_d;
  logic [10:0] idx_q, idx_d, eidx_q, eidx_d, oeidx_q, oeidx_d;
  logic [7:0]  exp_q, exp_d, dw_q, dw_d, odw_q, odw_d;
  logic [2:0]  dwhi_q, dwhi_d;
  logic [1:0]  kind_q, kind_d, okind_q, okind_d;
  logic        bb_q, bb_d, bd_q, bd_d, hdr_q, hdr_d, pld_q, pld_d, len_q, len_d;
  logic        done_q, done_d, ok_q, ok_d, ohdr_q, ohdr_d, opld_q, opld_d, olen_q, olen_d;
  logic [15:0] good_q, good_d, bad_q, bad_d;
  logic        fresh, in_hdr, hdr_ok, kind_ok, mis, frame_ok_c;
  logic [10:0] idx_c;
  logic [2:0]  typ;
  logic [1:0]  kind_c;
  assign fresh      = (state_q == IDLE) || (state_q == DONE);
  assign idx_c      = fresh ? 11'd0 : idx_q;
  assign in_hdr     = idx_c < 11'd22;
  assign typ        = s2p_din_i[2:0];
  assign kind_ok    = (bb_q && typ != 3'd0 && typ <= 3'd3) || (bd_q && typ == 3'd3);
  assign kind_c     = !kind_ok ? 2'd0 : bd_q ? 2'd3 : typ[1:0] - 2'd1;
  assign frame_ok_c = ~(hdr_q | pld_q | len_q);
  always_comb begin
    hdr_ok = (idx_c == 11'd0)                    ? (s2p_din_i == 8'hBB || s2p_din_i == 8'hBD) :
             (idx_c == 11'd1)                    ? (s2p_din_i == 8'h00) :
             (idx_c == 11'd2 || idx_c == 11'd4)  ? (s2p_din_i == 8'h07) :
             (idx_c == 11'd3 || idx_c == 11'd5)  ? (s2p_din_i == 8'hF9) :
             (idx_c < 11'd20)                    ? (s2p_din_i == 8'hFF) :
             (idx_c == 11'd20)                   ? (s2p_din_i[7:3] == 5'b01001) : kind_ok;
    mis    = din_valid_i && (in_hdr ? !hdr_ok : (!hdr_q && s2p_din_i != exp_q));
  end
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    exp_d   = exp_q;
    bb_d    = bb_q;
    bd_d    = bd_q;
    dwhi_d  = dwhi_q;
    kind_d  = kind_q;
    dw_d    = dw_q;
    hdr_d   = hdr_q;
    pld_d   = pld_q;
    len_d   = len_q;
    eidx_d  = eidx_q;
    done_d  = 1'b0;
    ok_d    = ok_q;
    okind_d = okind_q;
    odw_d   = odw_q;
    ohdr_d  = ohdr_q;
    opld_d  = opld_q;
    olen_d  = olen_q;
    oeidx_d = oeidx_q;
    good_d  = good_q;
    bad_d   = bad_q;
    if (state_q == DONE) begin
      done_d  = 1'b1;
      ok_d    = frame_ok_c;
      okind_d = kind_q;
      odw_d   = dw_q;
      ohdr_d  = hdr_q;
      opld_d  = pld_q;
      olen_d  = len_q;
      oeidx_d = eidx_q;
      good_d  = good_q + 16'(frame_ok_c && good_q != 16'hFFFF);
      bad_d   = bad_q + 16'(!frame_ok_c && bad_q != 16'hFFFF);
    end
    if (fresh) begin
      idx_d  = 11'd0;
      hdr_d  = 1'b0;
      pld_d  = 1'b0;
      len_d  = 1'b0;
      eidx_d = 11'd0;
      kind_d = 2'd0;
      dw_d   = 8'd0;
    end
    if (din_valid_i) begin
      if (mis && !hdr_d && !pld_d) eidx_d = idx_c;
      hdr_d  = hdr_d | (mis && in_hdr);
      pld_d  = pld_d | (mis && !in_hdr);
      bb_d   = (idx_c == 11'd0) ? (s2p_din_i == 8'hBB) : bb_q;
      bd_d   = (idx_c == 11'd0) ? (s2p_din_i == 8'hBD) : bd_q;
      dwhi_d = (idx_c == 11'd20) ? s2p_din_i[2:0] : dwhi_q;
      if (idx_c == 11'd21) begin
        kind_d = kind_c;
        dw_d   = {dwhi_q, s2p_din_i[7:3]};
      end
      exp_d   = (idx_c == 11'd21) ? 8'd3 - {6'd0, kind_c} : in_hdr ? exp_q : exp_q + 8'd1;
      idx_d   = idx_c + 11'd1;
      state_d = (idx_c == 11'd2047) ? DONE : (in_hdr && idx_c != 11'd21) ? HDR : PLD;
    end else if (!fresh) begin
      // truncated frame: error index is the number of bytes actually received
      if (!hdr_q && !pld_q) eidx_d = idx_q;
      len_d   = 1'b1;
      state_d = DONE;
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      exp_q   <= '0;
      bb_q    <= 1'b0;
      bd_q    <= 1'b0;
      dwhi_q  <= '0;
      kind_q  <= '0;
      dw_q    <= '0;
      hdr_q   <= 1'b0;
      pld_q   <= 1'b0;
      len_q   <= 1'b0;
      eidx_q  <= '0;
      done_q  <= 1'b0;
      ok_q    <= 1'b0;
      okind_q <= '0;
      odw_q   <= '0;
      ohdr_q  <= 1'b0;
      opld_q  <= 1'b0;
      olen_q  <= 1'b0;
      oeidx_q <= '0;
      good_q  <= '0;
      bad_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      exp_q   <= exp_d;
      bb_q    <= bb_d;
      bd_q    <= bd_d;
      dwhi_q  <= dwhi_d;
      kind_q  <= kind_d;
      dw_q    <= dw_d;
      hdr_q   <= hdr_d;
      pld_q   <= pld_d;
      len_q   <= len_d;
      eidx_q  <= eidx_d;
      done_q  <= done_d;
      ok_q    <= ok_d;
      okind_q <= okind_d;
      odw_q   <= odw_d;
      ohdr_q  <= ohdr_d;
      opld_q  <= opld_d;
      olen_q  <= olen_d;
      oeidx_q <= oeidx_d;
      good_q  <= good_d;
      bad_q   <= bad_d;
    end
  end
  assign frame_done_o = done_q;
  assign frame_ok_o   = ok_q;
  assign frame_kind_o = okind_q;
  assign dangwei_o    = odw_q;
  assign hdr_err_o    = ohdr_q;
  assign pld_err_o    = opld_q;
  assign len_err_o    = olen_q;
  assign err_idx_o    = oeidx_q;
  assign good_cnt_o   = good_q;
  assign bad_cnt_o    = bad_q;
endmodule
